mcu_spi_arbiter: RTL and testbench

//  Shares the single cartridge-to-MCU SPI bus (nMCUSel/SPIDo/SPIDi/SCK enable) between two masters:
//  the RTC bridge (port Rtc) and the host SPI controller (port Host). Registered grant FSM with

---
 rtl/mcu_spi_arbiter.sv | 133 +++++++++++++
 tb/tb_mcu_spi_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_arbiter.sv
// Arbitrates the cartridge-to-MCU SPI bus between the RTC bridge and the host SPI controller.
// Registered grant FSM with alternating priority, CS-high gap and a no-start watchdog.
module mcu_spi_arbiter #(
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic SClk,
    input  logic Reset,
    input  logic RtcReq,
    output logic RtcGrant,
    input  logic RtcnSel,
    input  logic RtcClkRunning,
    input  logic RtcClkStretch,
    input  logic RtcDo,
    output logic RtcDi,
    input  logic HostReq,
    output logic HostGrant,
    input  logic HostnSel,
    input  logic HostClkRunning,
    input  logic HostClkStretch,
    input  logic HostDo,
    output logic HostDi,
    output logic nMCUSel,
    output logic SPIDo,
    input  logic SPIDi,
    output logic SPIClkEn,
    output logic Busy
);

    localparam int unsigned CntMax = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StOwnRtc, StOwnHost, StGap} state_e;

    state_e          state_q, state_d;
    logic            last_rtc_q, last_rtc_d;
    logic            started_q, started_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic own_rtc, own_host;
    logic own_req, own_nsel, own_run, own_stretch, own_do;

    assign own_rtc  = (state_q == StOwnRtc);
    assign own_host = (state_q == StOwnHost);

    // Only the current owner's signals ever reach the bus; idle values otherwise.
    always_comb begin
        own_req     = 1'b0;
        own_nsel    = 1'b1;
        own_run     = 1'b0;
        own_stretch = 1'b0;
        own_do      = 1'b1;
        if (own_rtc) begin
            own_req     = RtcReq;
            own_nsel    = RtcnSel;
            own_run     = RtcClkRunning;
            own_stretch = RtcClkStretch;
            own_do      = RtcDo;
        end else if (own_host) begin
            own_req     = HostReq;
            own_nsel    = HostnSel;
            own_run     = HostClkRunning;
            own_stretch = HostClkStretch;
            own_do      = HostDo;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_rtc_d = last_rtc_q;
        started_d  = started_q;
        unique case (state_q)
            StIdle: begin
                started_d = 1'b0;
                // On a tie the master that did not own the bus last wins.
                if (RtcReq && (!HostReq || !last_rtc_q)) begin
                    state_d = StOwnRtc;
                end else if (HostReq) begin
                    state_d = StOwnHost;
                end
            end
            StOwnRtc, StOwnHost: begin
                started_d = started_q | ~own_nsel;
                if ((started_q && own_nsel) ||
                    (!started_d && (!own_req || cnt_q == CntW'(START_TIMEOUT - 1)))) begin
                    state_d    = StGap;
                    last_rtc_d = own_rtc;
                end
            end
            StGap: begin
                started_d = 1'b0;
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntW'(CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge SClk) begin
        if (Reset) begin
            state_q    <= StIdle;
            last_rtc_q <= 1'b0;
            started_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_rtc_q <= last_rtc_d;
            started_q  <= started_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        RtcGrant  = own_rtc;
        HostGrant = own_host;
        Busy      = (state_q != StIdle);
        nMCUSel   = own_nsel;
        SPIDo     = own_do;
        SPIClkEn  = (own_rtc | own_host) & ~own_nsel & own_run & ~own_stretch;
        RtcDi     = own_rtc ? SPIDi : 1'b1;
        HostDi    = own_host ? SPIDi : 1'b1;
    end

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Self-checking bench for mcu_spi_arbiter: grant latency, priority, gap, SCK gating,
// watchdog, reset abort and non-owner isolation.
module tb_mcu_spi_arbiter;

    logic SClk, Reset;
    logic RtcReq, RtcGrant, RtcnSel, RtcClkRunning, RtcClkStretch, RtcDo, RtcDi;
    logic HostReq, HostGrant, HostnSel, HostClkRunning, HostClkStretch, HostDo, HostDi;
    logic nMCUSel, SPIDo, SPIDi, SPIClkEn, Busy;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    mcu_spi_arbiter #(.GAP_CYCLES(2), .START_TIMEOUT(16)) dut (
        .SClk(SClk), .Reset(Reset),
        .RtcReq(RtcReq), .RtcGrant(RtcGrant), .RtcnSel(RtcnSel),
        .RtcClkRunning(RtcClkRunning), .RtcClkStretch(RtcClkStretch),
        .RtcDo(RtcDo), .RtcDi(RtcDi),
        .HostReq(HostReq), .HostGrant(HostGrant), .HostnSel(HostnSel),
        .HostClkRunning(HostClkRunning), .HostClkStretch(HostClkStretch),
        .HostDo(HostDo), .HostDi(HostDi),
        .nMCUSel(nMCUSel), .SPIDo(SPIDo), .SPIDi(SPIDi), .SPIClkEn(SPIClkEn), .Busy(Busy)
    );

    initial SClk = 1'b0;
    always #5 SClk = ~SClk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge SClk);
        #1;
    endtask

    task automatic idle_inputs();
        RtcReq = 0; RtcnSel = 1; RtcClkRunning = 0; RtcClkStretch = 0; RtcDo = 1;
        HostReq = 0; HostnSel = 1; HostClkRunning = 0; HostClkStretch = 0; HostDo = 1;
        SPIDi = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        tick();
        tick();
        Reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        SPIDi = 0;
        Reset = 1;
        tick();
        checks++; if (RtcGrant !== 0) begin errors++; $display("FAIL reset_rtcgrant: got %b want 0", RtcGrant); end
        checks++; if (HostGrant !== 0) begin errors++; $display("FAIL reset_hostgrant: got %b want 0", HostGrant); end
        checks++; if (nMCUSel !== 1) begin errors++; $display("FAIL reset_nmcusel: got %b want 1", nMCUSel); end
        checks++; if (SPIDo !== 1) begin errors++; $display("FAIL reset_spido: got %b want 1", SPIDo); end
        checks++; if (SPIClkEn !== 0) begin errors++; $display("FAIL reset_clken: got %b want 0", SPIClkEn); end
        checks++; if (RtcDi !== 1) begin errors++; $display("FAIL reset_rtcdi: got %b want 1", RtcDi); end
        checks++; if (HostDi !== 1) begin errors++; $display("FAIL reset_hostdi: got %b want 1", HostDi); end
        checks++; if (Busy !== 0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Reset = 0;
        SPIDi = 1;
    endtask

    task automatic test_rtc_grant();
        RtcReq = 1;
        #1;
        checks++; if (RtcGrant !== 0) begin errors++; $display("FAIL grant_latency: got %b want 0", RtcGrant); end
        tick();
        checks++; if (RtcGrant !== 1) begin errors++; $display("FAIL rtc_grant: got %b want 1", RtcGrant); end
        checks++; if (HostGrant !== 0) begin errors++; $display("FAIL rtc_hostgrant: got %b want 0", HostGrant); end
        checks++; if (Busy !== 1) begin errors++; $display("FAIL rtc_busy: got %b want 1", Busy); end
        RtcClkRunning = 1;
        #1;
        checks++; if (SPIClkEn !== 0) begin errors++; $display("FAIL clk_nsel_high: got %b want 0", SPIClkEn); end
        checks++; if (nMCUSel !== 1) begin errors++; $display("FAIL nsel_follow_hi: got %b want 1", nMCUSel); end
        RtcnSel = 0;
        #1;
        checks++; if (nMCUSel !== 0) begin errors++; $display("FAIL nsel_follow_lo: got %b want 0", nMCUSel); end
        checks++; if (SPIClkEn !== 1) begin errors++; $display("FAIL clk_running: got %b want 1", SPIClkEn); end
        tick();
        RtcClkRunning = 0; RtcnSel = 1; RtcReq = 0;
        tick();
        checks++; if (RtcGrant !== 0 || HostGrant !== 0) begin
            errors++; $display("FAIL rtc_end_grant: got %b%b want 00", RtcGrant, HostGrant);
        end
        tick();
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        RtcReq = 1; HostReq = 1;
        tick();
        checks++; if ({RtcGrant, HostGrant} !== 2'b10) begin
            errors++; $display("FAIL tie_after_reset: got %b%b want 10", RtcGrant, HostGrant);
        end
        RtcnSel = 0;
        tick();
        tick();
        RtcnSel = 1;   // RtcReq stays high: a fresh request competing with host
        #1;
        checks++; if (nMCUSel !== 1 || RtcGrant !== 1) begin
            errors++; $display("FAIL end_cycle: got nsel=%b grant=%b want 1 1", nMCUSel, RtcGrant);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({Busy, nMCUSel, RtcGrant, HostGrant} !== 4'b1100) begin
                errors++; $display("FAIL gap_%0d: got %b want 1100", i, {Busy, nMCUSel, RtcGrant, HostGrant});
            end
        end
        tick();
        checks++; if (Busy !== 0 || HostGrant !== 0) begin
            errors++; $display("FAIL gap_idle: got busy=%b hg=%b want 0 0", Busy, HostGrant);
        end
        tick();
        checks++; if ({RtcGrant, HostGrant} !== 2'b01) begin
            errors++; $display("FAIL alternate: got %b%b want 01", RtcGrant, HostGrant);
        end
        HostnSel = 0;
        tick();
        HostnSel = 1; HostReq = 0;
        repeat (4) tick();
        checks++; if ({RtcGrant, HostGrant} !== 2'b10) begin
            errors++; $display("FAIL rtc_pending: got %b%b want 10", RtcGrant, HostGrant);
        end
        RtcReq = 0;
        tick();
        checks++; if (RtcGrant !== 0 || Busy !== 1) begin
            errors++; $display("FAIL withdraw: got grant=%b busy=%b want 0 1", RtcGrant, Busy);
        end
        tick();
        tick();
    endtask

    task automatic test_stretch();
        logic [7:0] data;
        logic stretch;
        int b;
        int pulses;
        logic [1:0] exp;
        data = 8'($urandom);
        b = 0;
        pulses = 0;
        RtcReq = 1;
        tick();
        RtcnSel = 0;
        for (int i = 0; i < 13; i++) begin
            stretch = (i >= 4 && i <= 8);
            RtcClkRunning = 1;
            RtcClkStretch = stretch;
            SPIDi = 1'($urandom);
            HostnSel = 1'($urandom); HostClkRunning = 1'($urandom); HostDo = 1'($urandom);
            if (!stretch) begin
                RtcDo = data[7 - b];
                exp_q.push_back({RtcDo, SPIDi});
                b++;
            end else begin
                RtcDo = 1'($urandom);
            end
            #1;
            checks++; if (nMCUSel !== 0 || HostDi !== 1 || HostGrant !== 0) begin
                errors++; $display("FAIL isolate_%0d: got nsel=%b hdi=%b hg=%b want 0 1 0", i, nMCUSel, HostDi, HostGrant);
            end
            if (SPIClkEn === 1) begin
                pulses++;
                checks++; if (stretch) begin errors++; $display("FAIL stretch_pulse_%0d: got 1 want 0", i); end
                checks++; if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_pulse_%0d: got pulse want none", i);
                end else begin
                    exp = exp_q.pop_front();
                    if ({SPIDo, RtcDi} !== exp) begin
                        errors++; $display("FAIL bit_%0d: got do/di=%b want %b", i, {SPIDo, RtcDi}, exp);
                    end
                end
            end else if (!stretch) begin
                checks++; errors++; $display("FAIL missing_pulse_%0d: got 0 want 1", i);
            end
            tick();
        end
        checks++; if (pulses != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL pulse_count: got %0d left %0d want 8 left 0", pulses, exp_q.size());
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        int n;
        HostReq = 1;
        tick();
        RtcReq = 1;
        n = 0;
        while (HostGrant === 1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL watchdog_len: got %0d want 16", n); end
        checks++; if (nMCUSel !== 1 || Busy !== 1) begin
            errors++; $display("FAIL watchdog_gap: got nsel=%b busy=%b want 1 1", nMCUSel, Busy);
        end
        tick();
        tick();
        checks++; if (RtcGrant !== 0 || Busy !== 0) begin
            errors++; $display("FAIL watchdog_idle: got rg=%b busy=%b want 0 0", RtcGrant, Busy);
        end
        tick();
        checks++; if ({RtcGrant, HostGrant} !== 2'b10) begin
            errors++; $display("FAIL after_watchdog: got %b%b want 10", RtcGrant, HostGrant);
        end
        RtcReq = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (HostGrant !== 1 && n < 10) begin
            n++;
            tick();
        end
        checks++; if (HostGrant !== 1) begin errors++; $display("FAIL host_regrant: got %b want 1", HostGrant); end
        HostnSel = 0; HostClkRunning = 1;
        #1;
        checks++; if (nMCUSel !== 0 || SPIClkEn !== 1) begin
            errors++; $display("FAIL host_xfer: got nsel=%b en=%b want 0 1", nMCUSel, SPIClkEn);
        end
        Reset = 1;
        tick();
        checks++; if ({nMCUSel, HostGrant, SPIClkEn, Busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_abort: got %b want 1000", {nMCUSel, HostGrant, SPIClkEn, Busy});
        end
        Reset = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        Reset = 1;
        test_reset();
        test_rtc_grant();
        test_priority();
        test_stretch();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
